// File: rtl/ftile_rx_mac_seg_to_mfb.sv
// F-Tile MAC segmented RX to MFB adapter: INFRAME/EOP_EMPTY flags become registered SOF/EOF/position/error.
// Optional frame/error statistics counters are enabled by defining FTILE_RX_ADAPT_STATS_EN.
module ftile_rx_mac_seg_to_mfb #(
    parameter int SEGMENTS = 4,
    parameter int REGIONS  = 1,
    localparam int REGION_SIZE = SEGMENTS / REGIONS,
    localparam int SOF_POS_W   = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1,
    localparam int EOF_POS_W   = $clog2(REGION_SIZE * 8)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [SEGMENTS*64-1:0]         in_data_i,
    input  logic [SEGMENTS-1:0]            in_inframe_i,
    input  logic [SEGMENTS*3-1:0]          in_eop_empty_i,
    input  logic [SEGMENTS-1:0]            in_fcs_error_i,
    input  logic [SEGMENTS*2-1:0]          in_error_i,
    input  logic [SEGMENTS*3-1:0]          in_status_data_i,
    input  logic                           in_valid_i,
    output logic [SEGMENTS*64-1:0]         out_data_o,
    output logic [REGIONS-1:0]             out_sof_o,
    output logic [REGIONS-1:0]             out_eof_o,
    output logic [REGIONS*SOF_POS_W-1:0]   out_sof_pos_o,
    output logic [REGIONS*EOF_POS_W-1:0]   out_eof_pos_o,
    output logic [REGIONS-1:0]             out_error_o,
    output logic                           out_src_rdy_o,
    output logic [31:0]                    out_frame_cnt_o,
    output logic [31:0]                    out_err_cnt_o
);

    // SYNC: discard segments until the first INFRAME=0 so a reset mid-frame yields no orphan EOF
    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]                   state_q, state_d;
    logic                         prev_inframe_q, prev_inframe_d;

    logic [SEGMENTS-1:0]          prev_s;
    logic [SEGMENTS-1:0]          mask_s;
    logic [SEGMENTS-1:0]          sop_s;
    logic [SEGMENTS-1:0]          eop_s;
    logic [SEGMENTS-1:0]          act_s;
    logic [SEGMENTS-1:0]          seg_err_s;
    logic                         seen_zero;

    logic [SEGMENTS*64-1:0]       data_q;
    logic [REGIONS-1:0]           sof_q, sof_d;
    logic [REGIONS-1:0]           eof_q, eof_d;
    logic [REGIONS*SOF_POS_W-1:0] sof_pos_q, sof_pos_d;
    logic [REGIONS*EOF_POS_W-1:0] eof_pos_q, eof_pos_d;
    logic [REGIONS-1:0]           err_q, err_d;
    logic                         src_rdy_q, src_rdy_d;

    logic                         unused_status;
    assign unused_status = ^in_status_data_i;

    always_comb begin
        prev_s    = '0;
        mask_s    = '0;
        sop_s     = '0;
        eop_s     = '0;
        act_s     = '0;
        seg_err_s = '0;
        seen_zero = 1'b0;
        prev_s[0] = prev_inframe_q;
        for (int i = 1; i < SEGMENTS; i++) begin
            prev_s[i] = in_inframe_i[i-1];
        end
        for (int i = 0; i < SEGMENTS; i++) begin
            mask_s[i]    = (state_q == ST_SYNC) && !seen_zero;
            seen_zero    = seen_zero | ~in_inframe_i[i];
            sop_s[i]     = in_inframe_i[i] & ~prev_s[i] & ~mask_s[i];
            eop_s[i]     = ~in_inframe_i[i] & prev_s[i] & ~mask_s[i];
            act_s[i]     = (in_inframe_i[i] & ~mask_s[i]) | eop_s[i];
            seg_err_s[i] = in_fcs_error_i[i] | (|in_error_i[2*i +: 2]);
        end
    end

    always_comb begin
        state_d        = state_q;
        prev_inframe_d = prev_inframe_q;
        if (in_valid_i) begin
            prev_inframe_d = in_inframe_i[SEGMENTS-1];
            if (state_q == ST_SYNC && seen_zero) begin
                state_d = ST_RUN;
            end
        end
    end

    // Minimum frame length guarantees at most one SOP and one EOP per region
    always_comb begin
        sof_d     = '0;
        eof_d     = '0;
        sof_pos_d = '0;
        eof_pos_d = '0;
        err_d     = '0;
        src_rdy_d = in_valid_i & (|act_s);
        if (in_valid_i) begin
            for (int r = 0; r < REGIONS; r++) begin
                for (int j = 0; j < REGION_SIZE; j++) begin
                    if (sop_s[r*REGION_SIZE + j]) begin
                        sof_d[r] = 1'b1;
                        sof_pos_d[r*SOF_POS_W +: SOF_POS_W] = SOF_POS_W'(j);
                    end
                    if (eop_s[r*REGION_SIZE + j]) begin
                        eof_d[r] = 1'b1;
                        eof_pos_d[r*EOF_POS_W +: EOF_POS_W] =
                            EOF_POS_W'(j*8 + 7 - int'(in_eop_empty_i[3*(r*REGION_SIZE + j) +: 3]));
                        err_d[r] = seg_err_s[r*REGION_SIZE + j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_SYNC;
            prev_inframe_q <= 1'b0;
            data_q         <= '0;
            sof_q          <= '0;
            eof_q          <= '0;
            sof_pos_q      <= '0;
            eof_pos_q      <= '0;
            err_q          <= '0;
            src_rdy_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_inframe_q <= prev_inframe_d;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            sof_pos_q <= sof_pos_d;
            eof_pos_q <= eof_pos_d;
            err_q     <= err_d;
            src_rdy_q <= src_rdy_d;
        end
    end

    assign out_data_o    = data_q;
    assign out_sof_o     = sof_q;
    assign out_eof_o     = eof_q;
    assign out_sof_pos_o = sof_pos_q;
    assign out_eof_pos_o = eof_pos_q;
    assign out_error_o   = err_q;
    assign out_src_rdy_o = src_rdy_q;

`ifdef FTILE_RX_ADAPT_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [31:0] err_cnt_q;
    logic [31:0] eof_num;
    logic [31:0] err_num;

    always_comb begin
        eof_num = '0;
        err_num = '0;
        for (int r = 0; r < REGIONS; r++) begin
            eof_num = eof_num + 32'(eof_d[r]);
            err_num = err_num + 32'(eof_d[r] & err_d[r]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_q + eof_num;
            err_cnt_q   <= err_cnt_q + err_num;
        end
    end

    assign out_frame_cnt_o = frame_cnt_q;
    assign out_err_cnt_o   = err_cnt_q;
`else
    assign out_frame_cnt_o = '0;
    assign out_err_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_ftile_rx_mac_seg_to_mfb.sv
// Directed bench for ftile_rx_mac_seg_to_mfb (SEGMENTS=4, REGIONS=1).
// Inframe vectors are written [3:0], so bit 0 is segment 0.
module tb_ftile_rx_mac_seg_to_mfb;

    localparam int SEGMENTS = 4;
    localparam int REGIONS  = 1;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [SEGMENTS*64-1:0] in_data_i;
    logic [SEGMENTS-1:0]    in_inframe_i;
    logic [SEGMENTS*3-1:0]  in_eop_empty_i;
    logic [SEGMENTS-1:0]    in_fcs_error_i;
    logic [SEGMENTS*2-1:0]  in_error_i;
    logic [SEGMENTS*3-1:0]  in_status_data_i;
    logic                   in_valid_i;
    logic [SEGMENTS*64-1:0] out_data_o;
    logic [REGIONS-1:0]     out_sof_o;
    logic [REGIONS-1:0]     out_eof_o;
    logic [1:0]             out_sof_pos_o;
    logic [4:0]             out_eof_pos_o;
    logic [REGIONS-1:0]     out_error_o;
    logic                   out_src_rdy_o;
    logic [31:0]            out_frame_cnt_o;
    logic [31:0]            out_err_cnt_o;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0]  data_cnt = 32'h1000;
    logic [255:0] last_data;

    ftile_rx_mac_seg_to_mfb #(.SEGMENTS(SEGMENTS), .REGIONS(REGIONS)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .in_data_i        (in_data_i),
        .in_inframe_i     (in_inframe_i),
        .in_eop_empty_i   (in_eop_empty_i),
        .in_fcs_error_i   (in_fcs_error_i),
        .in_error_i       (in_error_i),
        .in_status_data_i (in_status_data_i),
        .in_valid_i       (in_valid_i),
        .out_data_o       (out_data_o),
        .out_sof_o        (out_sof_o),
        .out_eof_o        (out_eof_o),
        .out_sof_pos_o    (out_sof_pos_o),
        .out_eof_pos_o    (out_eof_pos_o),
        .out_error_o      (out_error_o),
        .out_src_rdy_o    (out_src_rdy_o),
        .out_frame_cnt_o  (out_frame_cnt_o),
        .out_err_cnt_o    (out_err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Applies one word, then samples 1 ns after the capturing edge
    task automatic send(input logic [3:0] infr, input logic [11:0] empty,
                        input logic [3:0] fcs, input logic [7:0] err, input logic vld);
        data_cnt         = data_cnt + 32'd1;
        in_data_i        = {8{data_cnt}};
        in_inframe_i     = infr;
        in_eop_empty_i   = empty;
        in_fcs_error_i   = fcs;
        in_error_i       = err;
        in_status_data_i = 12'hFFF;
        in_valid_i       = vld;
        if (vld) last_data = {8{data_cnt}};
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        #2;
        chk("rst_src_rdy", 256'(out_src_rdy_o), 256'(0));
        chk("rst_sof",     256'(out_sof_o),     256'(0));
        chk("rst_eof",     256'(out_eof_o),     256'(0));
        chk("rst_frame_cnt", 256'(out_frame_cnt_o), 256'(0));
        rst_i = 1'b0;
    endtask

    logic [31:0] exp_frames;
    logic [31:0] exp_errs;

    initial begin
        rst_i            = 1'b1;
        in_data_i        = '0;
        in_inframe_i     = '0;
        in_eop_empty_i   = '0;
        in_fcs_error_i   = '0;
        in_error_i       = '0;
        in_status_data_i = '0;
        in_valid_i       = 1'b0;
        last_data        = '0;
        #12;
        chk("reset_src_rdy", 256'(out_src_rdy_o), 256'(0));
        chk("reset_sof",     256'(out_sof_o),     256'(0));
        chk("reset_eof",     256'(out_eof_o),     256'(0));
        chk("reset_eof_pos", 256'(out_eof_pos_o), 256'(0));
        chk("reset_error",   256'(out_error_o),   256'(0));
        chk("reset_data",    out_data_o,          256'(0));
        chk("reset_err_cnt", 256'(out_err_cnt_o), 256'(0));
        rst_i = 1'b0;

        // Idle word leaves SYNC without producing output
        send(4'b0000, 12'h000, 4'h0, 8'h00, 1'b1);
        chk("idle_src_rdy", 256'(out_src_rdy_o), 256'(0));

        // Test 1: simple frame
        send(4'b1111, 12'h000, 4'h0, 8'h00, 1'b1);
        chk("t1a_sof",     256'(out_sof_o),     256'(1));
        chk("t1a_sof_pos", 256'(out_sof_pos_o), 256'(0));
        chk("t1a_src_rdy", 256'(out_src_rdy_o), 256'(1));
        chk("t1a_eof",     256'(out_eof_o),     256'(0));
        chk("t1a_data",    out_data_o,          last_data);
        send(4'b0000, 12'h000, 4'h0, 8'h00, 1'b1);
        chk("t1b_eof",     256'(out_eof_o),     256'(1));
        chk("t1b_eof_pos", 256'(out_eof_pos_o), 256'(7));
        chk("t1b_error",   256'(out_error_o),   256'(0));
        chk("t1b_sof",     256'(out_sof_o),     256'(0));
        chk("t1b_src_rdy", 256'(out_src_rdy_o), 256'(1));

        // Test 2: EOP in seg2, empty 3, FCS error
        send(4'b1111, 12'h000, 4'h0, 8'h00, 1'b1);
        chk("t2a_sof", 256'(out_sof_o), 256'(1));
        send(4'b0011, 12'h0C0, 4'b0100, 8'h00, 1'b1);
        chk("t2b_eof",     256'(out_eof_o),     256'(1));
        chk("t2b_eof_pos", 256'(out_eof_pos_o), 256'(20));
        chk("t2b_error",   256'(out_error_o),   256'(1));
        chk("t2b_sof",     256'(out_sof_o),     256'(0));

        // Test 3: EOF in seg0 then SOF in seg1 of the same word
        send(4'b1111, 12'h000, 4'h0, 8'h00, 1'b1);
        send(4'b1110, 12'h005, 4'h0, 8'h00, 1'b1);
        chk("t3_eof",     256'(out_eof_o),     256'(1));
        chk("t3_eof_pos", 256'(out_eof_pos_o), 256'(2));
        chk("t3_sof",     256'(out_sof_o),     256'(1));
        chk("t3_sof_pos", 256'(out_sof_pos_o), 256'(1));
        chk("t3_error",   256'(out_error_o),   256'(0));

        // Test 4: 3-cycle gap mid-frame; garbage inframe while invalid must be ignored
        for (int g = 0; g < 3; g++) begin
            send(4'b0000, 12'h000, 4'h0, 8'h00, 1'b0);
            chk("t4_gap_src_rdy", 256'(out_src_rdy_o), 256'(0));
            chk("t4_gap_eof",     256'(out_eof_o),     256'(0));
        end
        send(4'b1111, 12'h000, 4'h0, 8'h00, 1'b1);
        chk("t4_resume_sof",     256'(out_sof_o),     256'(0));
        chk("t4_resume_src_rdy", 256'(out_src_rdy_o), 256'(1));
        chk("t4_resume_data",    out_data_o,          last_data);
        send(4'b0111, 12'h200, 4'h0, 8'h00, 1'b1);
        chk("t4_eof",     256'(out_eof_o),     256'(1));
        chk("t4_eof_pos", 256'(out_eof_pos_o), 256'(30));
        send(4'b0000, 12'h000, 4'h0, 8'h00, 1'b1);
        chk("t4_idle_src_rdy", 256'(out_src_rdy_o), 256'(0));

        // MAC error code alone flags the frame
        send(4'b1111, 12'h000, 4'h0, 8'h00, 1'b1);
        send(4'b0000, 12'h000, 4'h0, 8'b0000_0010, 1'b1);
        chk("errcode_eof",   256'(out_eof_o),   256'(1));
        chk("errcode_error", 256'(out_error_o), 256'(1));

`ifdef FTILE_RX_ADAPT_STATS_EN
        exp_frames = 32'd5;
        exp_errs   = 32'd2;
`else
        exp_frames = 32'd0;
        exp_errs   = 32'd0;
`endif
        chk("cnt_frames_a", 256'(out_frame_cnt_o), 256'(exp_frames));
        chk("cnt_errs_a",   256'(out_err_cnt_o),   256'(exp_errs));

        // Test 5: reset mid-frame
        send(4'b1111, 12'h000, 4'h0, 8'h00, 1'b1);
        chk("t5_pre_sof", 256'(out_sof_o), 256'(1));
        pulse_reset();
        send(4'b1111, 12'h000, 4'h0, 8'h00, 1'b1);
        chk("t5_w1_src_rdy", 256'(out_src_rdy_o), 256'(0));
        chk("t5_w1_sof",     256'(out_sof_o),     256'(0));
        send(4'b1110, 12'h002, 4'h0, 8'h00, 1'b1);
        chk("t5_w2_eof",     256'(out_eof_o),     256'(0));
        chk("t5_w2_sof",     256'(out_sof_o),     256'(1));
        chk("t5_w2_sof_pos", 256'(out_sof_pos_o), 256'(1));
        chk("t5_w2_src_rdy", 256'(out_src_rdy_o), 256'(1));
        send(4'b0000, 12'h000, 4'h0, 8'h00, 1'b1);
        chk("t5_w3_eof",     256'(out_eof_o),     256'(1));
        chk("t5_w3_eof_pos", 256'(out_eof_pos_o), 256'(7));

        // Test 6: 100 frames, 7 with MAC error code 01
        pulse_reset();
        send(4'b0000, 12'h000, 4'h0, 8'h00, 1'b1);
        for (int i = 0; i < 100; i++) begin
            send(4'b1111, 12'h000, 4'h0, 8'h00, 1'b1);
            send(4'b0000, 12'h000, 4'h0, (i % 15 == 0) ? 8'h01 : 8'h00, 1'b1);
            chk("t6_eof",   256'(out_eof_o),   256'(1));
            chk("t6_error", 256'(out_error_o), 256'((i % 15 == 0) ? 1 : 0));
        end
`ifdef FTILE_RX_ADAPT_STATS_EN
        exp_frames = 32'd100;
        exp_errs   = 32'd7;
`else
        exp_frames = 32'd0;
        exp_errs   = 32'd0;
`endif
        chk("t6_frame_cnt", 256'(out_frame_cnt_o), 256'(exp_frames));
        chk("t6_err_cnt",   256'(out_err_cnt_o),   256'(exp_errs));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
